// File: rtl/mon_commit_checker_if.sv
// Retirement monitor stream: one commit record per cycle, qualified by mon_valid.
interface mon_commit_checker_if;
  logic        mon_valid;
  logic [63:0] mon_order;
  logic [31:0] mon_inst;
  logic [4:0]  mon_rd_addr;
  logic [31:0] mon_rd_wdata;
  logic [31:0] mon_pc_rdata;
  logic [31:0] mon_pc_wdata;
  logic [3:0]  mon_mem_rmask;
  logic [3:0]  mon_mem_wmask;

  modport master (
    output mon_valid, mon_order, mon_inst, mon_rd_addr, mon_rd_wdata,
           mon_pc_rdata, mon_pc_wdata, mon_mem_rmask, mon_mem_wmask
  );

  modport slave (
    input  mon_valid, mon_order, mon_inst, mon_rd_addr, mon_rd_wdata,
           mon_pc_rdata, mon_pc_wdata, mon_mem_rmask, mon_mem_wmask
  );
endinterface

// File: rtl/mon_commit_checker.sv
// Commit-stream checker: validates order, PC chain, x0 writes and memory masks,
// detects halt (jal x0,0) and commit starvation, and latches sticky halt/error status.
module mon_commit_checker #(
  parameter logic [31:0] START_PC        = 32'h1ECEB000,
  parameter int          WATCHDOG_CYCLES = 10000,
  parameter logic [31:0] HALT_INST       = 32'h0000006F
) (
  input  logic                 clk,
  input  logic                 rst,
  mon_commit_checker_if.slave  mon,
  output logic                 halt,
  output logic                 error,
  output logic [2:0]           err_code,
  output logic [63:0]          err_order,
  output logic [63:0]          retired_count
);

  localparam int WD_W = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_ORDER     = 3'd1;
  localparam logic [2:0] CODE_PC        = 3'd2;
  localparam logic [2:0] CODE_X0_WRITE  = 3'd3;
  localparam logic [2:0] CODE_MEM_BOTH  = 3'd4;
  localparam logic [2:0] CODE_TIMEOUT   = 3'd5;
  localparam logic [2:0] CODE_POST_HALT = 3'd6;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    RUN        = 2'd1,
    HALTED     = 2'd2,
    ERRORED    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            halt_q, halt_d;
  logic            error_q, error_d;
  logic [2:0]      err_code_q, err_code_d;
  logic [63:0]     err_order_q, err_order_d;
  logic [63:0]     retired_q, retired_d;
  logic [63:0]     exp_order_q, exp_order_d;
  logic [31:0]     exp_pc_q, exp_pc_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [2:0]      fail_code;

  // Lowest-numbered failing check wins when several apply to one commit.
  always_comb begin
    fail_code = CODE_NONE;
    if (mon.mon_order != exp_order_q)
      fail_code = CODE_ORDER;
    else if (mon.mon_pc_rdata != exp_pc_q)
      fail_code = CODE_PC;
    else if (mon.mon_rd_addr == 5'd0 && mon.mon_rd_wdata != 32'd0)
      fail_code = CODE_X0_WRITE;
    else if (|mon.mon_mem_rmask && |mon.mon_mem_wmask)
      fail_code = CODE_MEM_BOTH;
  end

  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    err_order_d = err_order_q;
    retired_d   = retired_q;
    exp_order_d = exp_order_q;
    exp_pc_d    = exp_pc_q;
    wd_d        = wd_q;

    case (state_q)
      WAIT_FIRST, RUN: begin
        if (mon.mon_valid) begin
          if (fail_code != CODE_NONE) begin
            state_d     = ERRORED;
            error_d     = 1'b1;
            err_code_d  = fail_code;
            err_order_d = mon.mon_order;
          end else begin
            retired_d   = retired_q + 64'd1;
            exp_order_d = mon.mon_order + 64'd1;
            exp_pc_d    = mon.mon_pc_wdata;
            wd_d        = '0;
            if (mon.mon_inst == HALT_INST) begin
              state_d = HALTED;
              halt_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end else if (wd_q == WD_LAST) begin
          state_d     = ERRORED;
          error_d     = 1'b1;
          err_code_d  = CODE_TIMEOUT;
          err_order_d = 64'd0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      HALTED: begin
        // Watchdog stays frozen; only a stray commit can end this state.
        if (mon.mon_valid) begin
          state_d     = ERRORED;
          error_d     = 1'b1;
          err_code_d  = CODE_POST_HALT;
          err_order_d = mon.mon_order;
        end
      end
      default: ; // ERRORED holds everything until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_FIRST;
      halt_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= CODE_NONE;
      err_order_q <= 64'd0;
      retired_q   <= 64'd0;
      exp_order_q <= 64'd0;
      exp_pc_q    <= START_PC;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      err_order_q <= err_order_d;
      retired_q   <= retired_d;
      exp_order_q <= exp_order_d;
      exp_pc_q    <= exp_pc_d;
      wd_q        <= wd_d;
    end
  end

  assign halt          = halt_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign err_order     = err_order_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_mon_commit_checker.sv
// Bench for mon_commit_checker: directed commit streams, a per-cycle reference model
// compare, and literal expectations for each scenario.
module tb_mon_commit_checker;

  localparam logic [31:0] START = 32'h1ECEB000;
  localparam logic [31:0] HALTI = 32'h0000006F;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int          WD    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        halt, error;
  logic [2:0]  err_code;
  logic [63:0] err_order, retired_count;

  int n_total = 0;
  int n_pass  = 0;

  mon_commit_checker_if mon_if ();

  mon_commit_checker #(
    .START_PC(START), .WATCHDOG_CYCLES(WD), .HALT_INST(HALTI)
  ) dut (
    .clk(clk), .rst(rst), .mon(mon_if.slave),
    .halt(halt), .error(error), .err_code(err_code),
    .err_order(err_order), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: status derived from the commit rules directly, idle time as a plain count.
  logic        started = 1'b0;
  logic        m_halt, m_err;
  logic [2:0]  m_code;
  logic [63:0] m_eorder, m_count, m_next_order;
  logic [31:0] m_next_pc;
  int          m_idle;

  function automatic logic [2:0] first_fail();
    if (mon_if.mon_order != m_next_order) return 3'd1;
    if (mon_if.mon_pc_rdata != m_next_pc) return 3'd2;
    if (mon_if.mon_rd_addr == 0 && mon_if.mon_rd_wdata != 0) return 3'd3;
    if (mon_if.mon_mem_rmask != 0 && mon_if.mon_mem_wmask != 0) return 3'd4;
    return 3'd0;
  endfunction

  always @(posedge clk) begin
    logic [2:0] c;
    if (rst) begin
      started <= 1'b1;
      m_halt <= 0; m_err <= 0; m_code <= 0; m_eorder <= 0; m_count <= 0;
      m_next_order <= 0; m_next_pc <= START; m_idle <= 0;
    end else if (!m_err) begin
      if (m_halt) begin
        if (mon_if.mon_valid) begin
          m_err <= 1; m_code <= 6; m_eorder <= mon_if.mon_order;
        end
      end else if (mon_if.mon_valid) begin
        c = first_fail();
        m_idle <= 0;
        if (c != 0) begin
          m_err <= 1; m_code <= c; m_eorder <= mon_if.mon_order;
        end else begin
          m_count      <= m_count + 1;
          m_next_order <= mon_if.mon_order + 1;
          m_next_pc    <= mon_if.mon_pc_wdata;
          if (mon_if.mon_inst == HALTI) m_halt <= 1;
        end
      end else if (m_idle + 1 == WD) begin
        m_err <= 1; m_code <= 5; m_eorder <= 0;
      end else begin
        m_idle <= m_idle + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("halt", {63'd0, halt}, {63'd0, m_halt});
      chk("error", {63'd0, error}, {63'd0, m_err});
      chk("err_code", {61'd0, err_code}, {61'd0, m_code});
      chk("err_order", err_order, m_eorder);
      chk("retired_count", retired_count, m_count);
    end
  end

  task automatic commit(input logic [63:0] order, input logic [31:0] inst,
                        input logic [4:0] rd, input logic [31:0] wd,
                        input logic [31:0] pc, input logic [31:0] npc,
                        input logic [3:0] rm, input logic [3:0] wm);
    mon_if.mon_valid     = 1'b1;
    mon_if.mon_order     = order;
    mon_if.mon_inst      = inst;
    mon_if.mon_rd_addr   = rd;
    mon_if.mon_rd_wdata  = wd;
    mon_if.mon_pc_rdata  = pc;
    mon_if.mon_pc_wdata  = npc;
    mon_if.mon_mem_rmask = rm;
    mon_if.mon_mem_wmask = wm;
    @(negedge clk);
    mon_if.mon_valid = 1'b0;
    $display("commit order=%0d pc=%h npc=%h inst=%h -> halt=%0b err=%0b code=%0d retired=%0d",
             order, pc, npc, inst, halt, error, err_code, retired_count);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic h, input logic e,
                            input logic [2:0] code, input logic [63:0] eo, input logic [63:0] cnt);
    #1;
    chk({tag, ".halt"}, {63'd0, halt}, {63'd0, h});
    chk({tag, ".error"}, {63'd0, error}, {63'd0, e});
    chk({tag, ".err_code"}, {61'd0, err_code}, {61'd0, code});
    chk({tag, ".err_order"}, err_order, eo);
    chk({tag, ".retired"}, retired_count, cnt);
    chk({tag, ".model_count"}, m_count, cnt);
  endtask

  initial begin
    mon_if.mon_valid = 0; mon_if.mon_order = 0; mon_if.mon_inst = 0;
    mon_if.mon_rd_addr = 0; mon_if.mon_rd_wdata = 0; mon_if.mon_pc_rdata = 0;
    mon_if.mon_pc_wdata = 0; mon_if.mon_mem_rmask = 0; mon_if.mon_mem_wmask = 0;

    // Reset state
    do_reset();
    expect_out("reset", 0, 0, 0, 0, 0);

    // Clean three-commit run ending in halt
    commit(0, NOP,   5'd1, 32'd7, START,        START + 4, 4'h0, 4'h0);
    commit(1, NOP,   5'd2, 32'd0, START + 4,    START + 8, 4'hF, 4'h0);
    commit(2, HALTI, 5'd0, 32'd0, START + 8,    START + 8, 4'h0, 4'h0);
    idle(20);
    expect_out("halt_run", 1, 0, 0, 0, 3);

    // Out-of-order commit
    do_reset();
    commit(0, NOP, 5'd1, 32'd1, START,     START + 4, 4'h0, 4'h0);
    commit(2, NOP, 5'd1, 32'd1, START + 4, START + 8, 4'h0, 4'h0);
    idle(2);
    expect_out("order", 0, 1, 1, 2, 1);

    // Broken PC chain
    do_reset();
    commit(0, NOP, 5'd1, 32'd1, START,      START + 4,  4'h0, 4'h0);
    commit(1, NOP, 5'd1, 32'd1, START + 16, START + 20, 4'h0, 4'h0);
    expect_out("pc", 0, 1, 2, 1, 1);

    // x0 write outranks simultaneous load/store masks
    do_reset();
    commit(0, NOP, 5'd0, 32'd5, START, START + 4, 4'hF, 4'h3);
    expect_out("x0", 0, 1, 3, 0, 0);

    // Load and store masks together
    do_reset();
    commit(0, NOP, 5'd3, 32'd5, START, START + 4, 4'h1, 4'h8);
    expect_out("mem_both", 0, 1, 4, 0, 0);

    // Watchdog fires on exactly the 16th idle cycle
    do_reset();
    idle(WD - 1);
    expect_out("wd_before", 0, 0, 0, 0, 0);
    idle(1);
    expect_out("wd_fire", 0, 1, 5, 0, 0);
    // ERRORED ignores further commits
    commit(0, NOP, 5'd0, 32'd9, START, START + 4, 4'h0, 4'h0);
    expect_out("wd_hold", 0, 1, 5, 0, 0);

    // Watchdog restarts on each accepted commit
    do_reset();
    idle(10);
    commit(0, NOP, 5'd1, 32'd1, START, START + 4, 4'h0, 4'h0);
    idle(WD - 2);
    expect_out("wd_restart", 0, 0, 0, 0, 1);

    // Commit after halt
    do_reset();
    commit(0, HALTI, 5'd0, 32'd0, START, START, 4'h0, 4'h0);
    commit(1, NOP,   5'd1, 32'd1, START, START + 4, 4'h0, 4'h0);
    expect_out("post_halt", 1, 1, 6, 1, 1);

    // Mid-stream reset, then restart from order 0
    do_reset();
    commit(0, NOP, 5'd1, 32'd1, START,     START + 4, 4'h0, 4'h0);
    commit(1, NOP, 5'd1, 32'd1, START + 4, START + 8, 4'h0, 4'h0);
    rst = 1'b1;
    idle(1);
    expect_out("mid_rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    commit(0, NOP, 5'd1, 32'd1, START, START + 4, 4'h0, 4'h0);
    expect_out("restart", 0, 0, 0, 0, 1);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
